wdog_regs_gen2: RTL and testbench

Parametrised second-generation watchdog with a register interface. Adds a configurable counter width, a clock prescaler, a key-sequence unlock/lock FSM and a two-stage timeout: the first expiry raises an interrupt, and a second expiry without a kick fires a reset pulse. It sits on the same simple register bus (WRITE/ADDR/WDATA/RDATA) as the other peripheral register blocks, and drives the system reset controller and interrupt controller.

---
 rtl/wdog_pkg.sv | 37 +++
 rtl/wdog_prescaler.sv | 42 ++++
 rtl/wdog_regs_gen2.sv | 204 ++++++++++++++++++++
 tb/tb_wdog_regs_gen2.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdog_pkg.sv
// ============================================================================
//  Module      : wdog_pkg
//  Description : Shared constants and types for the wdog_regs_gen2 watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wdog_pkg;

    // Word addresses of the register map
    localparam logic [7:0] ADDR_CTRL     = 8'h0;
    localparam logic [7:0] ADDR_LOAD     = 8'h1;
    localparam logic [7:0] ADDR_VALUE    = 8'h2;
    localparam logic [7:0] ADDR_KEY      = 8'h3;
    localparam logic [7:0] ADDR_STATUS   = 8'h4;
    localparam logic [7:0] ADDR_PRESCALE = 8'h5;

    localparam logic [31:0] KEY_A    = 32'h0000_1ACC;
    localparam logic [31:0] KEY_B    = 32'h0000_E5A1;
    localparam logic [31:0] KEY_KICK = 32'h0000_AA55;

    typedef enum logic [1:0] {
        KS_IDLE  = 2'd0,
        KS_GOT_A = 2'd1,
        KS_GOT_B = 2'd2
    } key_state_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_INTEN_BIT  = 1;
    localparam int STAT_TO1_BIT    = 0;
    localparam int STAT_RSTF_BIT   = 1;
    localparam int STAT_KEYERR_BIT = 2;
    localparam int STAT_STAGE_BIT  = 3;

endpackage

`default_nettype wire

// File: rtl/wdog_prescaler.sv
// ============================================================================
//  Module      : wdog_prescaler
//  Description : Reloadable down-counter emitting one tick per (reload+1)
//                enabled cycles; held at the reload value while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdog_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             enable,
    input  logic [PRE_W-1:0] reload,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == '0);

    // Tracking reload while disabled makes the count restart cleanly when EN rises
    always_comb begin
        cnt_d = reload;
        if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - PRE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wdog_regs_gen2.sv
// ============================================================================
//  Module      : wdog_regs_gen2
//  Description : Two-stage watchdog with key-sequence unlock and register bus.
//                Optional macro WDOG_LOCK_EN freezes LOAD/PRESCALE/INTEN
//                while the watchdog is enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdog_regs_gen2
    import wdog_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              IRQ,
    output logic              WDOG_RST
);

    key_state_e       key_state_q, key_state_d;
    logic             en_q, en_d;
    logic             inten_q, inten_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stage_q, stage_d;
    logic             to1_q, to1_d;
    logic             rstf_q, rstf_d;
    logic             keyerr_q, keyerr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wdog_rst_q, wdog_rst_d;

    logic wr_ctrl, wr_load, wr_key, wr_status, wr_prescale;
    logic tick, kick, en_seq, dis_seq, key_err, cfg_err, cfg_locked;
    logic exp_stage0, exp_stage1;
    logic [2:0] w1c;

    assign wr_ctrl     = WRITE && (ADDR == ADDR_W'(ADDR_CTRL));
    assign wr_load     = WRITE && (ADDR == ADDR_W'(ADDR_LOAD));
    assign wr_key      = WRITE && (ADDR == ADDR_W'(ADDR_KEY));
    assign wr_status   = WRITE && (ADDR == ADDR_W'(ADDR_STATUS));
    assign wr_prescale = WRITE && (ADDR == ADDR_W'(ADDR_PRESCALE));

`ifdef WDOG_LOCK_EN
    assign cfg_locked = en_q;
`else
    assign cfg_locked = 1'b0;
`endif

    wdog_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .CLK    (CLK),
        .RESETn (RESETn),
        .enable (en_q),
        .reload (prescale_q),
        .tick   (tick)
    );

    always_comb begin
        key_state_d = key_state_q;
        kick        = 1'b0;
        en_seq      = 1'b0;
        dis_seq     = 1'b0;
        key_err     = 1'b0;
        if (wr_key) begin
            key_state_d = KS_IDLE;
            case (key_state_q)
                KS_IDLE: begin
                    if (WDATA == KEY_A)         key_state_d = KS_GOT_A;
                    else if (WDATA == KEY_B)    key_state_d = KS_GOT_B;
                    else if (WDATA == KEY_KICK) kick        = en_q;
                    else                        key_err     = en_q;
                end
                KS_GOT_A: begin
                    if (WDATA == KEY_B) en_seq  = 1'b1;
                    else                key_err = 1'b1;
                end
                KS_GOT_B: begin
                    if (WDATA == KEY_A) dis_seq = 1'b1;
                    else                key_err = 1'b1;
                end
                default: key_state_d = KS_IDLE;
            endcase
        end
    end

    // Disable beats kick/enable, which in turn beat a same-cycle expiry
    always_comb begin
        en_d       = en_q;
        count_d    = count_q;
        stage_d    = stage_q;
        exp_stage0 = 1'b0;
        exp_stage1 = 1'b0;
        if (dis_seq) begin
            en_d = 1'b0;
        end else if (en_seq || kick) begin
            en_d    = 1'b1;
            count_d = load_q;
            stage_d = 1'b0;
        end else if (tick) begin
            if (count_q == '0) begin
                count_d    = load_q;
                stage_d    = ~stage_q;
                exp_stage0 = ~stage_q;
                exp_stage1 = stage_q;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        inten_d    = inten_q;
        load_d     = load_q;
        prescale_d = prescale_q;
        cfg_err    = 1'b0;
        w1c        = '0;
        if (wr_ctrl || wr_load || wr_prescale) begin
            if (cfg_locked) begin
                cfg_err = 1'b1;
            end else begin
                if (wr_ctrl)     inten_d    = WDATA[CTRL_INTEN_BIT];
                if (wr_load)     load_d     = WDATA[CNT_W-1:0];
                if (wr_prescale) prescale_d = WDATA[PRE_W-1:0];
            end
        end
        if (wr_status) begin
            w1c = WDATA[2:0];
        end
    end

    // Set has priority over a same-cycle write-one-to-clear
    assign to1_d      = (to1_q    & ~w1c[STAT_TO1_BIT])    | exp_stage0;
    assign rstf_d     = (rstf_q   & ~w1c[STAT_RSTF_BIT])   | exp_stage1;
    assign keyerr_d   = (keyerr_q & ~w1c[STAT_KEYERR_BIT]) | key_err | cfg_err;
    assign irq_d      = to1_d & inten_d;
    assign wdog_rst_d = exp_stage1;

    always_comb begin
        rdata_d = '0;
        case (ADDR)
            ADDR_W'(ADDR_CTRL): begin
                rdata_d[CTRL_EN_BIT]    = en_q;
                rdata_d[CTRL_INTEN_BIT] = inten_q;
            end
            ADDR_W'(ADDR_LOAD):     rdata_d = 32'(load_q);
            ADDR_W'(ADDR_VALUE):    rdata_d = 32'(count_q);
            ADDR_W'(ADDR_STATUS): begin
                rdata_d[STAT_TO1_BIT]    = to1_q;
                rdata_d[STAT_RSTF_BIT]   = rstf_q;
                rdata_d[STAT_KEYERR_BIT] = keyerr_q;
                rdata_d[STAT_STAGE_BIT]  = stage_q;
            end
            ADDR_W'(ADDR_PRESCALE): rdata_d = 32'(prescale_q);
            default:                rdata_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            key_state_q <= KS_IDLE;
            en_q        <= 1'b0;
            inten_q     <= 1'b0;
            load_q      <= '1;
            prescale_q  <= '0;
            count_q     <= '1;
            stage_q     <= 1'b0;
            to1_q       <= 1'b0;
            rstf_q      <= 1'b0;
            keyerr_q    <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            wdog_rst_q  <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            en_q        <= en_d;
            inten_q     <= inten_d;
            load_q      <= load_d;
            prescale_q  <= prescale_d;
            count_q     <= count_d;
            stage_q     <= stage_d;
            to1_q       <= to1_d;
            rstf_q      <= rstf_d;
            keyerr_q    <= keyerr_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            wdog_rst_q  <= wdog_rst_d;
        end
    end

    assign RDATA    = rdata_q;
    assign IRQ      = irq_q;
    assign WDOG_RST = wdog_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_wdog_regs_gen2.sv
// ============================================================================
//  Module      : tb_wdog_regs_gen2
//  Description : Directed and randomized self-checking bench for wdog_regs_gen2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wdog_regs_gen2;

    localparam logic [31:0] C_KEY_A    = 32'h0000_1ACC;
    localparam logic [31:0] C_KEY_B    = 32'h0000_E5A1;
    localparam logic [31:0] C_KEY_KICK = 32'h0000_AA55;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        WRITE = 1'b0;
    logic [3:0]  ADDR = '0;
    logic [31:0] WDATA = '0;
    logic [31:0] RDATA;
    logic        IRQ;
    logic        WDOG_RST;

    int checks = 0;
    int errors = 0;

    wdog_regs_gen2 dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .WRITE    (WRITE),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .RDATA    (RDATA),
        .IRQ      (IRQ),
        .WDOG_RST (WDOG_RST)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: watchdog state in plain variables, one update per clock
    logic        m_en, m_inten, m_stage, m_to1, m_rstf, m_keyerr, m_irq, m_wrst;
    logic [31:0] m_load, m_cnt, m_rdata;
    logic [7:0]  m_pre, m_pwait;
    int          m_ks;  // 0 idle, 1 saw KEY_A, 2 saw KEY_B

    task automatic model_reset();
        m_en = 0; m_inten = 0; m_stage = 0; m_to1 = 0; m_rstf = 0; m_keyerr = 0;
        m_irq = 0; m_wrst = 0; m_load = '1; m_cnt = '1; m_rdata = '0;
        m_pre = '0; m_pwait = '0; m_ks = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'h0: return {30'd0, m_inten, m_en};
            4'h1: return m_load;
            4'h2: return m_cnt;
            4'h4: return {28'd0, m_stage, m_keyerr, m_rstf, m_to1};
            4'h5: return {24'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic tick, kick, en_seq, dis_seq, kerr, exp0, exp1, locked;
        logic [2:0] w1c;
        logic [7:0] pwait_n;
        m_rdata = model_read(ADDR);
        tick = m_en && (m_pwait == 0);
        pwait_n = (!m_en || tick) ? m_pre : m_pwait - 8'd1;
        kick = 0; en_seq = 0; dis_seq = 0; kerr = 0; exp0 = 0; exp1 = 0; w1c = '0;
`ifdef WDOG_LOCK_EN
        locked = m_en;
`else
        locked = 0;
`endif
        if (WRITE && ADDR == 4'h3) begin
            if (m_ks == 0) begin
                m_ks = (WDATA == C_KEY_A) ? 1 : (WDATA == C_KEY_B) ? 2 : 0;
                if (WDATA == C_KEY_KICK) kick = m_en;
                else if (m_ks == 0) kerr = m_en;
            end else begin
                if (m_ks == 1 && WDATA == C_KEY_B) en_seq = 1;
                else if (m_ks == 2 && WDATA == C_KEY_A) dis_seq = 1;
                else kerr = 1;
                m_ks = 0;
            end
        end
        if (WRITE && (ADDR == 4'h0 || ADDR == 4'h1 || ADDR == 4'h5)) begin
            if (locked) kerr = 1;
            else if (ADDR == 4'h0) m_inten = WDATA[1];
        end
        if (WRITE && ADDR == 4'h4) w1c = WDATA[2:0];
        if (dis_seq) begin
            m_en = 0;
        end else if (en_seq || kick) begin
            m_en = 1; m_cnt = m_load; m_stage = 0;
        end else if (tick) begin
            if (m_cnt == 0) begin
                exp0 = !m_stage; exp1 = m_stage;
                m_stage = !m_stage; m_cnt = m_load;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        // LOAD/PRESCALE updates land after the reload, which used the old LOAD
        if (WRITE && !locked && ADDR == 4'h1) m_load = WDATA;
        if (WRITE && !locked && ADDR == 4'h5) m_pre = WDATA[7:0];
        m_pwait  = pwait_n;
        m_to1    = (m_to1 & ~w1c[0]) | exp0;
        m_rstf   = (m_rstf & ~w1c[1]) | exp1;
        m_keyerr = (m_keyerr & ~w1c[2]) | kerr;
        m_irq    = m_to1 & m_inten;
        m_wrst   = exp1;
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        WRITE = 1'b1; ADDR = a; WDATA = d;
        step();
        WRITE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        WRITE = 1'b0; ADDR = a;
        step();
        d = RDATA;
    endtask

    task automatic do_reset();
        RESETn = 1'b0; WRITE = 1'b0;
        #1;
        model_reset();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_v [6];
        do_reset();
        exp_v = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        for (int a = 0; a < 6; a++) begin
            rd(4'(a), d);
            checks++;
            if (d !== exp_v[a]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_v[a]);
            end
        end
        rd(4'h9, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_unmapped: got %h expected 0", d); end
        checks++;
        if (IRQ !== 1'b0 || WDOG_RST !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: IRQ=%b WDOG_RST=%b expected 0 0", IRQ, WDOG_RST);
        end
    endtask

    task automatic test_two_stage();
        logic [31:0] d;
        int rst_seen;
        wr(4'h1, 32'd10); wr(4'h5, 32'd0); wr(4'h0, 32'h2);
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_B);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL stage1_early_irq: got %b expected 0", IRQ); end
        step();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL stage1_irq: got %b expected 1", IRQ); end
        rst_seen = 0;
        for (int i = 0; i < 10; i++) begin step(); if (WDOG_RST) rst_seen++; end
        checks++;
        if (rst_seen != 0) begin errors++; $display("FAIL stage2_early_rst: got %0d pulses expected 0", rst_seen); end
        step();
        checks++;
        if (WDOG_RST !== 1'b1) begin errors++; $display("FAIL stage2_rst: got %b expected 1", WDOG_RST); end
        step();
        checks++;
        if (WDOG_RST !== 1'b0) begin errors++; $display("FAIL stage2_pulse_width: got %b expected 0", WDOG_RST); end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL stage2_status: got %h expected 3", d); end
        wr(4'h3, C_KEY_B); wr(4'h3, C_KEY_A); wr(4'h4, 32'h7);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", IRQ); end
    endtask

    task automatic test_kick_periodic();
        logic [31:0] d;
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_B);
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 4; j++) begin
                rd(4'h2, d);
                checks++;
                if (d < 32'd5) begin errors++; $display("FAIL kick_value: got %0d expected >= 5", d); end
            end
            wr(4'h3, C_KEY_KICK);
        end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL kick_status: got %h expected 0", d); end
        wr(4'h3, C_KEY_B); wr(4'h3, C_KEY_A);
    endtask

    task automatic test_key_errors();
        logic [31:0] d;
        wr(4'h4, 32'h7);
        wr(4'h3, 32'h0000_1234);
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL badkey_disabled: got %h expected 0", d); end
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_KICK); wr(4'h3, C_KEY_B);
        rd(4'h0, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL broken_seq_ctrl: got %h expected 2", d); end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL broken_seq_keyerr: got %h expected 4", d); end
        wr(4'h3, C_KEY_A);
        wr(4'h4, 32'h7);
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_B);
        rd(4'h0, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL enable_ctrl: got %h expected 3", d); end
        wr(4'h3, C_KEY_B); wr(4'h3, C_KEY_A);
        rd(4'h0, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL disable_ctrl: got %h expected 2", d); end
        for (int i = 0; i < 6; i++) step();
        rd(4'h2, d);
        checks++;
        if (d !== 32'd8) begin errors++; $display("FAIL frozen_value: got %0d expected 8", d); end
    endtask

    task automatic test_prescale_race();
        logic [31:0] d;
        wr(4'h4, 32'h7); wr(4'h1, 32'd2); wr(4'h5, 32'd3);
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_B);
        for (int i = 0; i < 11; i++) step();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL pre_early_irq: got %b expected 0", IRQ); end
        step();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL pre_irq_12: got %b expected 1", IRQ); end
        wr(4'h3, C_KEY_B); wr(4'h3, C_KEY_A); wr(4'h4, 32'h7);
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_B);
        for (int i = 0; i < 11; i++) step();
        wr(4'h3, C_KEY_KICK);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL race_irq: got %b expected 0", IRQ); end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL race_status: got %h expected 0", d); end
        wr(4'h3, C_KEY_B); wr(4'h3, C_KEY_A);
    endtask

    task automatic test_lock();
        logic [31:0] d;
        wr(4'h4, 32'h7);
        wr(4'h3, C_KEY_A); wr(4'h3, C_KEY_B);
        wr(4'h1, 32'd5);
        rd(4'h1, d);
        checks++;
`ifdef WDOG_LOCK_EN
        if (d !== 32'd2) begin errors++; $display("FAIL lock_load: got %0d expected 2", d); end
`else
        if (d !== 32'd5) begin errors++; $display("FAIL lock_load: got %0d expected 5", d); end
`endif
        rd(4'h4, d);
        checks++;
`ifdef WDOG_LOCK_EN
        if ((d & 32'h4) !== 32'h4) begin errors++; $display("FAIL lock_keyerr: got %h expected bit2 set", d); end
`else
        if ((d & 32'h4) !== 32'h0) begin errors++; $display("FAIL lock_keyerr: got %h expected bit2 clear", d); end
`endif
        wr(4'h3, C_KEY_B); wr(4'h3, C_KEY_A);
        wr(4'h1, 32'd7);
        rd(4'h1, d);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL unlocked_load: got %0d expected 7", d); end
    endtask

    task automatic test_random();
        int op;
        int sel;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 900) begin
                #2 RESETn = 1'b0;
                #1;
                checks++;
                if (RDATA !== 32'h0 || IRQ !== 1'b0 || WDOG_RST !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: RDATA=%h IRQ=%b WDOG_RST=%b expected 0 0 0", RDATA, IRQ, WDOG_RST);
                end
                model_reset();
                @(posedge CLK); #1;
                RESETn = 1'b1;
            end
            op = $urandom_range(0, 11);
            WRITE = 1'b1;
            WDATA = $urandom;
            case (op)
                0, 1, 2, 3: begin
                    ADDR = 4'h3;
                    sel = $urandom_range(0, 4);
                    WDATA = (sel == 0) ? C_KEY_A : (sel == 1) ? C_KEY_B :
                            (sel <= 3) ? C_KEY_KICK : WDATA;
                end
                4: begin ADDR = 4'h1; WDATA = 32'($urandom_range(0, 12)); end
                5: begin ADDR = 4'h5; WDATA = 32'($urandom_range(0, 3)); end
                6: ADDR = 4'h0;
                7: ADDR = 4'h4;
                8: ADDR = 4'($urandom_range(6, 15));
                default: begin WRITE = 1'b0; ADDR = 4'($urandom_range(0, 15)); end
            endcase
            step();
            WRITE = 1'b0;
            checks++;
            if (RDATA !== m_rdata) begin
                errors++; $display("FAIL rand_rdata cyc %0d: got %h expected %h", i, RDATA, m_rdata);
            end
            checks++;
            if (IRQ !== m_irq) begin
                errors++; $display("FAIL rand_irq cyc %0d: got %b expected %b", i, IRQ, m_irq);
            end
            checks++;
            if (WDOG_RST !== m_wrst) begin
                errors++; $display("FAIL rand_wdog_rst cyc %0d: got %b expected %b", i, WDOG_RST, m_wrst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_stage();
        test_kick_periodic();
        test_key_errors();
        test_prescale_race();
        test_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
